// File: rtl/uart_tx_writer_pkg.sv
// uart_tx_writer_pkg: shared defaults and FSM state encoding for the UART TX writer
//   DATA_WIDTH_DEF : default byte width (matches transmitter data input)
//   FIFO_DEPTH_DEF : default buffer depth (power of 2, >= 2)
//   state_t        : writer FSM states IDLE / LAUNCH / WAIT_DONE
package uart_tx_writer_pkg;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int FIFO_DEPTH_DEF = 16;
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/uart_tx_writer_sync_fifo.sv
// uart_tx_writer_sync_fifo: show-ahead synchronous FIFO with level counter and flush
//   clk, rstn     : clock, asynchronous active-low reset
//   push, wr_data : write request and data (ignored when full or flushing)
//   pop           : remove head word (ignored when empty or flushing)
//   flush         : synchronous clear of pointers and level
//   head          : current head word (valid when !empty)
//   level         : entries held, 0..FIFO_DEPTH
//   empty, full   : level==0 / level==FIFO_DEPTH
module uart_tx_writer_sync_fifo
    import uart_tx_writer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] head,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  empty,
    output logic                  full
);
    localparam int LW = ADDR_WIDTH + 1;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic                  push_ok;
    logic                  pop_ok;
    // A write while full is dropped even if a pop frees a slot in the same cycle;
    // flush overrides both directions.
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign empty   = level == '0;
    assign full    = level == LW'(FIFO_DEPTH);
    assign head    = mem[rptr];
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wptr] <= wr_data;
    end
    // Pointers wrap naturally because FIFO_DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            wptr  <= push_ok ? wptr + ADDR_WIDTH'(1) : wptr;
            rptr  <= pop_ok ? rptr + ADDR_WIDTH'(1) : rptr;
            level <= level + LW'(push_ok) - LW'(pop_ok);
        end
    end
endmodule

// File: rtl/uart_tx_writer.sv
// uart_tx_writer: buffers bytes from a valid/ready port and launches one UART frame per byte
//   clk, rstn        : clock, asynchronous active-low reset (shared with transmitter)
//   wr_valid/wr_data : write port; wr_ready = !fifo_full
//   flush            : synchronous FIFO clear; an in-flight frame still completes
//   tx_start         : registered one-cycle launch pulse
//   tx_data          : registered byte, changes only when a byte is popped
//   tx_busy, tx_done : transmitter status / end-of-frame pulse
//   fifo_level/empty/full : buffer status
//   writer_busy      : FSM not in IDLE
module uart_tx_writer
    import uart_tx_writer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  flush,
    output logic                  tx_start,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_busy,
    input  logic                  tx_done,
    output logic [ADDR_WIDTH:0]   fifo_level,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  writer_busy
);
    state_t                state;
    state_t                state_nx;
    logic                  launch;
    logic [DATA_WIDTH-1:0] head;
    uart_tx_writer_sync_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_fifo (
        .clk    (clk),
        .rstn   (rstn),
        .push   (wr_valid),
        .wr_data(wr_data),
        .pop    (launch),
        .flush  (flush),
        .head   (head),
        .level  (fifo_level),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );
    assign wr_ready    = !fifo_full;
    assign writer_busy = state != IDLE;
    // Only WAIT_DONE->IDLE on tx_done reopens launching, so a transmitter that
    // drops tx_busy early can never be relaunched before its done pulse.
    always_comb begin
        state_nx = state;
        launch   = 1'b0;
        case (state)
            IDLE: begin
                launch   = !fifo_empty && !tx_busy && !flush;
                state_nx = launch ? LAUNCH : IDLE;
            end
            LAUNCH:    state_nx = WAIT_DONE;
            WAIT_DONE: state_nx = tx_done ? IDLE : WAIT_DONE;
            default:   state_nx = IDLE;
        endcase
    end
    // tx_start/tx_data are registered, so transmitter status never reaches them combinationally.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            state    <= state_nx;
            tx_start <= launch;
            tx_data  <= launch ? head : tx_data;
        end
    end
endmodule

// File: tb/tb_uart_tx_writer.sv
// tb_uart_tx_writer: directed bench for uart_tx_writer with a behavioural transmitter
module tb_uart_tx_writer;
    localparam int FRAME = 10;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready;
    logic       flush = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_done;
    logic [4:0] fifo_level;
    logic       fifo_empty;
    logic       fifo_full;
    logic       writer_busy;
    logic       hold_busy = 1'b0;
    logic       busy_m;
    logic       done_m;
    int         cnt;
    int         vectors = 0;
    int         errors = 0;
    logic [7:0] launched[$];
    logic [7:0] hold_val = 8'h00;
    int         dones = 0;
    int         unstable = 0;
    int         overlap = 0;

    always #5 clk = ~clk;

    uart_tx_writer dut (
        .clk        (clk),
        .rstn       (rstn),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .flush      (flush),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .fifo_level (fifo_level),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .writer_busy(writer_busy)
    );

    // Transmitter model: busy for FRAME cycles after tx_start, then a one-cycle done.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_m <= 1'b0;
            done_m <= 1'b0;
            cnt    <= 0;
        end else begin
            done_m <= 1'b0;
            if (tx_start) begin
                busy_m <= 1'b1;
                cnt    <= FRAME;
            end else if (busy_m) begin
                if (cnt == 1) begin
                    busy_m <= 1'b0;
                    done_m <= 1'b1;
                end
                cnt <= cnt - 1;
            end
        end
    end
    assign tx_busy = busy_m | hold_busy;
    assign tx_done = done_m;

    always @(negedge clk) begin
        if (tx_start) begin
            launched.push_back(tx_data);
            hold_val = tx_data;
            if (busy_m) overlap++;
        end
        if (tx_done) dones++;
        if ((busy_m || tx_done) && tx_data !== hold_val) unstable++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        launched.delete();
        dones = 0;
        unstable = 0;
        overlap = 0;
    endtask

    task automatic wait_frames(input int n, input int limit, output bit ok);
        int k = 0;
        while ((launched.size() < n || dones < n) && k < limit) begin
            tick();
            k++;
        end
        ok = (launched.size() >= n && dones >= n);
    endtask

    task automatic wait_busy(input int limit, output bit ok);
        int k = 0;
        while (!busy_m && k < limit) begin
            tick();
            k++;
        end
        ok = busy_m;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick();
        tick();
        vectors++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got %b want 0", tx_start); end
        vectors++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
        vectors++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
        vectors++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
        vectors++; if ({fifo_empty, fifo_full, writer_busy} !== 3'b100) begin errors++; $display("FAIL reset_flags got %b want 100", {fifo_empty, fifo_full, writer_busy}); end
        rstn = 1'b1;
        clear_log();
        repeat (20) tick();
        vectors++; if (launched.size() != 0) begin errors++; $display("FAIL idle_no_start got %0d starts want 0", launched.size()); end
    endtask

    task automatic test_single();
        bit ok;
        clear_log();
        wr_valid = 1'b1;
        wr_data  = 8'hA5;
        tick();
        wr_valid = 1'b0;
        vectors++; if (fifo_level !== 5'd1) begin errors++; $display("FAIL single_level1 got %0d want 1", fifo_level); end
        vectors++; if (tx_start !== 1'b0) begin errors++; $display("FAIL single_early_start got %b want 0", tx_start); end
        tick();
        vectors++; if (tx_start !== 1'b1) begin errors++; $display("FAIL single_start got %b want 1", tx_start); end
        vectors++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_data got %h want a5", tx_data); end
        vectors++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL single_level0 got %0d want 0", fifo_level); end
        vectors++; if (writer_busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", writer_busy); end
        tick();
        vectors++; if (tx_start !== 1'b0) begin errors++; $display("FAIL single_pulse_width got %b want 0", tx_start); end
        wait_frames(1, 60, ok);
        vectors++; if (!ok) begin errors++; $display("FAIL single_timeout got %0d done want 1", dones); end
        tick();
        vectors++; if (writer_busy !== 1'b0) begin errors++; $display("FAIL single_idle got %b want 0", writer_busy); end
        vectors++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_hold got %h want a5", tx_data); end
        vectors++; if (launched.size() != 1 || unstable != 0) begin errors++; $display("FAIL single_count got %0d starts %0d unstable want 1 0", launched.size(), unstable); end
    endtask

    task automatic test_burst();
        bit ok;
        clear_log();
        hold_busy = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(i);
            tick();
        end
        vectors++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL burst_level got %0d want 16", fifo_level); end
        vectors++; if ({fifo_full, wr_ready} !== 2'b10) begin errors++; $display("FAIL burst_full got %b want 10", {fifo_full, wr_ready}); end
        wr_data = 8'hFF;
        tick();
        wr_valid = 1'b0;
        vectors++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL burst_drop got %0d want 16", fifo_level); end
        vectors++; if (launched.size() != 0) begin errors++; $display("FAIL burst_held got %0d starts want 0", launched.size()); end
        hold_busy = 1'b0;
        wait_frames(16, 16 * (FRAME + 6) + 20, ok);
        vectors++; if (!ok) begin errors++; $display("FAIL burst_timeout got %0d frames want 16", dones); end
        tick();
        tick();
        vectors++; if (launched.size() != 16 || dones != 16) begin errors++; $display("FAIL burst_count got %0d starts %0d dones want 16 16", launched.size(), dones); end
        for (int i = 0; i < 16 && i < launched.size(); i++) begin
            vectors++; if (launched[i] !== 8'(i + 1)) begin errors++; $display("FAIL burst_order[%0d] got %h want %h", i, launched[i], 8'(i + 1)); end
        end
        vectors++; if (unstable != 0 || overlap != 0) begin errors++; $display("FAIL burst_stable got %0d unstable %0d overlap want 0 0", unstable, overlap); end
    endtask

    task automatic test_full_pop();
        bit ok;
        clear_log();
        hold_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'h20 + 8'(i);
            tick();
        end
        wr_valid = 1'b0;
        vectors++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL fullpop_fill got %0d want 16", fifo_level); end
        hold_busy = 1'b0;
        wr_valid  = 1'b1;
        wr_data   = 8'h77;
        tick();
        wr_valid = 1'b0;
        vectors++; if (fifo_level !== 5'd15) begin errors++; $display("FAIL fullpop_level got %0d want 15", fifo_level); end
        vectors++; if (tx_start !== 1'b1 || tx_data !== 8'h20) begin errors++; $display("FAIL fullpop_launch got %b/%h want 1/20", tx_start, tx_data); end
        wait_frames(16, 16 * (FRAME + 6) + 20, ok);
        vectors++; if (!ok) begin errors++; $display("FAIL fullpop_timeout got %0d frames want 16", dones); end
        repeat (20) tick();
        vectors++; if (launched.size() != 16) begin errors++; $display("FAIL fullpop_count got %0d want 16", launched.size()); end
        vectors++; if (launched.size() == 16 && launched[15] !== 8'h2F) begin errors++; $display("FAIL fullpop_last got %h want 2f", launched[15]); end
    endtask

    task automatic test_flush();
        bit ok;
        clear_log();
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'h51 + 8'(i);
            tick();
        end
        wr_valid = 1'b0;
        vectors++; if (fifo_level !== 5'd4) begin errors++; $display("FAIL flush_queued got %0d want 4", fifo_level); end
        wait_busy(20, ok);
        vectors++; if (!ok) begin errors++; $display("FAIL flush_busy_timeout got %b want 1", busy_m); end
        flush    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'h99;
        tick();
        flush    = 1'b0;
        wr_valid = 1'b0;
        vectors++; if (fifo_level !== 5'd0 || fifo_empty !== 1'b1) begin errors++; $display("FAIL flush_level got %0d/%b want 0/1", fifo_level, fifo_empty); end
        vectors++; if (writer_busy !== 1'b1) begin errors++; $display("FAIL flush_inflight got %b want 1", writer_busy); end
        wait_frames(1, 40, ok);
        vectors++; if (!ok) begin errors++; $display("FAIL flush_done_timeout got %0d want 1", dones); end
        repeat (30) tick();
        vectors++; if (launched.size() != 1 || launched[0] !== 8'h51) begin errors++; $display("FAIL flush_starts got %0d starts want 1 (51)", launched.size()); end
        vectors++; if (writer_busy !== 1'b0) begin errors++; $display("FAIL flush_idle got %b want 0", writer_busy); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_log();
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'h61 + 8'(i);
            tick();
        end
        wr_valid = 1'b0;
        vectors++; if (fifo_level !== 5'd3) begin errors++; $display("FAIL rstmid_queued got %0d want 3", fifo_level); end
        wait_busy(20, ok);
        vectors++; if (!ok) begin errors++; $display("FAIL rstmid_busy_timeout got %b want 1", busy_m); end
        rstn = 1'b0;
        #1;
        vectors++; if ({tx_start, writer_busy, fifo_full} !== 3'b000) begin errors++; $display("FAIL rstmid_ctrl got %b want 000", {tx_start, writer_busy, fifo_full}); end
        vectors++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rstmid_data got %h want 00", tx_data); end
        vectors++; if (fifo_level !== 5'd0 || fifo_empty !== 1'b1 || wr_ready !== 1'b1) begin errors++; $display("FAIL rstmid_fifo got %0d/%b/%b want 0/1/1", fifo_level, fifo_empty, wr_ready); end
        repeat (3) tick();
        rstn = 1'b1;
        repeat (30) tick();
        vectors++; if (launched.size() != 1 || dones != 0) begin errors++; $display("FAIL rstmid_stale got %0d starts %0d dones want 1 0", launched.size(), dones); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_full_pop();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
